// File: rtl/divrem_seq_unit_pkg.sv
// Shared definitions for the sequential divide/remainder unit: op encodings,
// FSM state type and default width/counter sizing.
package divrem_seq_unit_pkg;

  localparam logic [1:0] DIVREM_DIV  = 2'b00;
  localparam logic [1:0] DIVREM_DIVU = 2'b01;
  localparam logic [1:0] DIVREM_REM  = 2'b10;
  localparam logic [1:0] DIVREM_REMU = 2'b11;

  localparam int DIVREM_DEF_WIDTH = 32;
  localparam int DIVREM_CNT_W     = $clog2(DIVREM_DEF_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } divrem_state_e;

endpackage

// File: rtl/divrem_signfix.sv
// Conditional two's-complement negate: absolute value at capture, sign fix at finalize.
// Purely combinational, no handshake.
module divrem_signfix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + 1'b1) : i_val;

endmodule

// File: rtl/divrem_seq_unit.sv
// RV32M DIV/DIVU/REM/REMU, restoring radix-2: WIDTH+1 cycle stall, one oReady pulse, iFlush aborts.
// DIVREM_EARLY_OUT_EN: divide-by-zero, signed overflow and |A|<|B| finish in 1 cycle.
module divrem_seq_unit
  import divrem_seq_unit_pkg::*;
#(
  parameter int WIDTH = DIVREM_DEF_WIDTH
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iStart,
  input  logic             iFlush,
  input  logic [1:0]       iOp,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic [WIDTH-1:0] oResult,
  output logic             oReady,
  output logic             oBusy
);

  localparam int CW = $clog2(WIDTH);

  divrem_state_e    r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_result;
  logic             r_is_rem;
  logic             r_qsign;
  logic             r_rsign;
  logic             r_ready;
  logic             r_busy;

  logic             w_signed;
  logic             w_is_rem;
  logic             w_a_neg;
  logic             w_b_neg;
  logic             w_b_zero;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;

  assign w_signed = (iOp == DIVREM_DIV) || (iOp == DIVREM_REM);
  assign w_is_rem = (iOp == DIVREM_REM) || (iOp == DIVREM_REMU);
  assign w_a_neg  = w_signed & iA[WIDTH-1];
  assign w_b_neg  = w_signed & iB[WIDTH-1];
  assign w_b_zero = (iB == '0);

  divrem_signfix #(.WIDTH(WIDTH)) u_abs_a (.i_val(iA), .i_neg(w_a_neg), .o_val(w_abs_a));
  divrem_signfix #(.WIDTH(WIDTH)) u_abs_b (.i_val(iB), .i_neg(w_b_neg), .o_val(w_abs_b));

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_rem_nxt;
  logic             w_ge;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_fin_val;
  logic             w_fin_neg;
  logic [WIDTH-1:0] w_fin_res;

  assign w_shift   = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
  // A set top bit means the shifted partial remainder exceeds any WIDTH-bit divisor.
  assign w_ge      = r_rem[WIDTH] | (w_shift >= {1'b0, r_dvs});
  assign w_rem_nxt = w_ge ? (w_shift - {1'b0, r_dvs}) : w_shift;
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

  assign w_fin_val = r_is_rem ? w_rem_nxt[WIDTH-1:0] : w_quo_nxt;
  assign w_fin_neg = r_is_rem ? r_rsign : r_qsign;

  divrem_signfix #(.WIDTH(WIDTH)) u_fin (.i_val(w_fin_val), .i_neg(w_fin_neg), .o_val(w_fin_res));

`ifdef DIVREM_EARLY_OUT_EN
  logic             w_ovf;
  logic             w_early;
  logic [WIDTH-1:0] w_early_res;

  assign w_ovf   = w_signed && (iA == {1'b1, {(WIDTH-1){1'b0}}}) && (iB == '1);
  assign w_early = w_b_zero || w_ovf || (w_abs_a < w_abs_b);

  always_comb begin
    w_early_res = w_is_rem ? iA : '0;
    if (w_b_zero) begin
      w_early_res = w_is_rem ? iA : '1;
    end else if (w_ovf) begin
      w_early_res = w_is_rem ? '0 : iA;
    end
  end
`endif

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_result <= '0;
      r_is_rem <= 1'b0;
      r_qsign  <= 1'b0;
      r_rsign  <= 1'b0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
    end else if (iFlush) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b0;
          if (iStart) begin
            r_is_rem <= w_is_rem;
            // Divide by zero keeps an all-ones quotient even for a negative dividend.
            r_qsign  <= (w_a_neg ^ w_b_neg) & ~w_b_zero;
            r_rsign  <= w_a_neg;
            r_rem    <= '0;
            r_quo    <= w_abs_a;
            r_dvs    <= w_abs_b;
            r_cnt    <= CW'(WIDTH - 1);
`ifdef DIVREM_EARLY_OUT_EN
            if (w_early) begin
              r_result <= w_early_res;
              r_ready  <= 1'b1;
              r_state  <= ST_DONE;
            end else begin
              r_busy  <= 1'b1;
              r_state <= ST_CALC;
            end
`else
            r_busy  <= 1'b1;
            r_state <= ST_CALC;
`endif
          end
        end
        ST_CALC: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          if (r_cnt == '0) begin
            r_result <= w_fin_res;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          r_ready <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign oResult = r_result;
  assign oReady  = r_ready;
  assign oBusy   = r_busy;

endmodule

// File: tb/tb_divrem_seq_unit.sv
// Scoreboard bench for divrem_seq_unit: results, latency, back-to-back, flush and reset.
// Expected latencies follow DIVREM_EARLY_OUT_EN when the bench is built with it.
module tb_divrem_seq_unit;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

`ifdef DIVREM_EARLY_OUT_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iStart;
  logic        iFlush;
  logic [1:0]  iOp;
  logic [31:0] iA;
  logic [31:0] iB;
  logic [31:0] oResult;
  logic        oReady;
  logic        oBusy;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp = 32'h0;

  divrem_seq_unit #(.WIDTH(32)) dut (
    .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iFlush(iFlush), .iOp(iOp),
    .iA(iA), .iB(iB), .oResult(oResult), .oReady(oReady), .oBusy(oBusy)
  );

  always #5 iCLK = ~iCLK;

  function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int   sa;
    int   sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_DIV:  if (b == 0) ref_model = 32'hFFFF_FFFF;
               else if (ovf) ref_model = a;
               else ref_model = sa / sb;
      OP_DIVU: if (b == 0) ref_model = 32'hFFFF_FFFF;
               else ref_model = a / b;
      OP_REM:  if (b == 0) ref_model = a;
               else if (ovf) ref_model = 32'h0;
               else ref_model = sa % sb;
      default: if (b == 0) ref_model = a;
               else ref_model = a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic        sgn;
    logic [31:0] aa;
    logic [31:0] ab;
    logic        early;
    sgn   = ~op[0];
    aa    = (sgn && a[31]) ? (~a + 32'd1) : a;
    ab    = (sgn && b[31]) ? (~b + 32'd1) : b;
    early = (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || (aa < ab);
    return (EARLY_EN && early) ? 1 : 33;
  endfunction

  // Called with inputs driven #1 after a rising edge and the DUT idle.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input string name);
    int          n;
    int          lat;
    bit          got;
    logic [31:0] e;
    exp_q.push_back(exp_res);
    lat    = exp_lat(op, a, b);
    iOp    = op;
    iA     = a;
    iB     = b;
    iStart = 1'b1;
    n      = 0;
    got    = 1'b0;
    while (!got && n < 100) begin
      @(posedge iCLK); #1;
      n++;
      if (n == 1 && lat > 1) begin
        vectors++;
        if (oBusy !== 1'b1) begin
          miscompares++;
          $display("FAIL %s busy: got %b expected 1", name, oBusy);
        end
      end
      if (oReady === 1'b1) begin
        got    = 1'b1;
        iStart = 1'b0;
        e      = exp_q.pop_front();
        last_exp = e;
        vectors++;
        if (oResult !== e) begin
          miscompares++;
          $display("FAIL %s result: got %h expected %h", name, oResult, e);
        end
        vectors++;
        if (n !== lat) begin
          miscompares++;
          $display("FAIL %s latency: got %0d expected %0d", name, n, lat);
        end
      end
    end
    if (!got) begin
      iStart = 1'b0;
      vectors++;
      miscompares++;
      void'(exp_q.pop_front());
      $display("FAIL %s timeout: got no oReady expected one within 100 cycles", name);
    end
    @(posedge iCLK); #1;
    vectors++;
    if (oReady !== 1'b0) begin
      miscompares++;
      $display("FAIL %s pulse width: got oReady=%b expected 0", name, oReady);
    end
  endtask

  task automatic test_reset();
    iRST = 1'b1; iStart = 1'b0; iFlush = 1'b0; iOp = 2'b00; iA = '0; iB = '0;
    repeat (2) @(posedge iCLK);
    #1;
    vectors++;
    if (oResult !== 32'h0) begin miscompares++; $display("FAIL reset result: got %h expected 0", oResult); end
    vectors++;
    if (oReady !== 1'b0) begin miscompares++; $display("FAIL reset ready: got %b expected 0", oReady); end
    vectors++;
    if (oBusy !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %b expected 0", oBusy); end
    iRST = 1'b0;
    @(posedge iCLK); #1;
  endtask

  task automatic test_basic();
    run_op(OP_DIV,  32'd100,      -32'sd7,  32'hFFFF_FFF2, "div_100_m7");
    run_op(OP_REM,  32'd100,      -32'sd7,  32'd2,         "rem_100_m7");
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd2,   32'h7FFF_FFFF, "divu_max_2");
    run_op(OP_REMU, 32'hFFFF_FFFF, 32'h10,  32'hF,         "remu_max_16");
    run_op(OP_REM,  -32'sd100,     32'd7,   -32'sd2,       "rem_m100_7");
  endtask

  task automatic test_special();
    run_op(OP_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, "div_by_zero");
    run_op(OP_REM,  32'd5,         32'd0,         32'd5,         "rem_by_zero");
    run_op(OP_DIV,  -32'sd5,       32'd0,         32'hFFFF_FFFF, "div_neg_by_zero");
    run_op(OP_REM,  -32'sd5,       32'd0,         -32'sd5,       "rem_neg_by_zero");
    run_op(OP_DIVU, 32'd9,         32'd0,         32'hFFFF_FFFF, "divu_by_zero");
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_overflow");
    run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         "rem_overflow");
    run_op(OP_DIV,  32'd3,         32'd10,        32'h0,         "div_small");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    for (int i = 0; i < 8; i++) begin
      a  = $urandom;
      b  = (i < 4) ? ($urandom >> $urandom_range(4, 28)) : $urandom;
      op = 2'($urandom_range(0, 3));
      run_op(op, a, b, ref_model(op, a, b), "random");
    end
  endtask

  task automatic test_back_to_back();
    int          n;
    int          pulses;
    int          t1;
    int          t2;
    logic [31:0] e;
    exp_q.push_back(32'd333);
    exp_q.push_back(-32'sd142);
    iOp = OP_DIV; iA = 32'd1000; iB = 32'd3; iStart = 1'b1;
    @(posedge iCLK); #1;
    // Second operands applied mid-CALC must not disturb the first divide.
    iA = -32'sd999; iB = 32'd7;
    n = 1; pulses = 0; t1 = 0; t2 = 0;
    while (n < 90) begin
      @(posedge iCLK); #1;
      n++;
      if (oReady === 1'b1) begin
        pulses++;
        if (pulses == 1) t1 = n;
        if (pulses == 2) begin t2 = n; iStart = 1'b0; end
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL b2b extra pulse: got oReady at cycle %0d expected none", n);
        end else begin
          e = exp_q.pop_front();
          last_exp = e;
          if (oResult !== e) begin
            miscompares++;
            $display("FAIL b2b result %0d: got %h expected %h", pulses, oResult, e);
          end
        end
      end
    end
    iStart = 1'b0;
    exp_q.delete();
    vectors++;
    if (pulses !== 2) begin miscompares++; $display("FAIL b2b pulses: got %0d expected 2", pulses); end
    vectors++;
    if (t1 !== 33) begin miscompares++; $display("FAIL b2b first latency: got %0d expected 33", t1); end
    vectors++;
    if (t2 - t1 !== 34) begin miscompares++; $display("FAIL b2b spacing: got %0d expected 34", t2 - t1); end
  endtask

  task automatic test_flush();
    int pulses;
    iOp = OP_DIVU; iA = 32'd1000; iB = 32'd3; iStart = 1'b1;
    repeat (10) @(posedge iCLK);
    #1;
    vectors++;
    if (oBusy !== 1'b1) begin miscompares++; $display("FAIL flush pre busy: got %b expected 1", oBusy); end
    iFlush = 1'b1;
    @(posedge iCLK); #1;
    iFlush = 1'b0; iStart = 1'b0;
    vectors++;
    if (oBusy !== 1'b0) begin miscompares++; $display("FAIL flush busy: got %b expected 0", oBusy); end
    vectors++;
    if (oResult !== last_exp) begin
      miscompares++;
      $display("FAIL flush result hold: got %h expected %h", oResult, last_exp);
    end
    pulses = 0;
    repeat (40) begin
      @(posedge iCLK); #1;
      if (oReady === 1'b1) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin miscompares++; $display("FAIL flush stray pulse: got %0d expected 0", pulses); end
    run_op(OP_DIV, 32'd100, -32'sd7, 32'hFFFF_FFF2, "after_flush");
  endtask

  task automatic test_reset_mid_calc();
    int pulses;
    iOp = OP_DIVU; iA = 32'd77777; iB = 32'd5; iStart = 1'b1;
    repeat (5) @(posedge iCLK);
    #2;
    iRST = 1'b1;
    #1;
    vectors++;
    if (oBusy !== 1'b0) begin miscompares++; $display("FAIL rst mid busy: got %b expected 0", oBusy); end
    vectors++;
    if (oResult !== 32'h0) begin miscompares++; $display("FAIL rst mid result: got %h expected 0", oResult); end
    iStart = 1'b0;
    @(posedge iCLK); #1;
    iRST = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge iCLK); #1;
      if (oReady === 1'b1) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin miscompares++; $display("FAIL rst mid stray pulse: got %0d expected 0", pulses); end
    run_op(OP_REMU, 32'd77777, 32'd5, 32'd2, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_special();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_mid_calc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
